// File: rtl/instr_fetch_unit.sv
// Fetch / instruction-register stage of the multicycle core: holds the PC,
// reads instruction memory, latches and decodes the instruction word.
module instr_fetch_unit #(
  parameter int               ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]       HALT_OP  = 6'h3F
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        State,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd,
  input  logic [31:0]       Mem_Data,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  output logic [31:0]       Instr,
  output logic [5:0]        Opcode,
  output logic [4:0]        Rd,
  output logic [4:0]        Rs1,
  output logic [4:0]        Rs2,
  output logic [31:0]       Imm_SExt,
  output logic [ADDR_W-1:0] Cur_PC,
  output logic [ADDR_W-1:0] Link_PC,
  output logic              Instr_Valid,
  output logic              Halted
);

  typedef enum logic [2:0] {
    RESET_STATE = 3'd0,
    FETCH_INSTR = 3'd1,
    READ_OPS    = 3'd2,
    EXECUTE     = 3'd3,
    WRITEBACK   = 3'd4
  } seq_state_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] cur_pc_q, cur_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  always_ff @(posedge Clk) begin
    pc_q     <= pc_d;
    instr_q  <= instr_d;
    cur_pc_q <= cur_pc_d;
    valid_q  <= valid_d;
    halted_q <= halted_d;
  end

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    cur_pc_d = cur_pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    // Reset overrides any branch or halt requested in the same cycle.
    if (Reset || State == RESET_STATE) begin
      pc_d     = RESET_PC;
      instr_d  = '0;
      cur_pc_d = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      case (State)
        FETCH_INSTR: begin
          if (!halted_q) begin
            instr_d  = Mem_Data;
            cur_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(1);
            valid_d  = 1'b1;
          end
        end
        EXECUTE: begin
          if (!halted_q) begin
            if (instr_q[31:26] == HALT_OP) begin
              halted_d = 1'b1;
            end else if (Branch_Taken) begin
              pc_d = Branch_Target;
            end
          end
        end
        WRITEBACK: valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign Mem_Addr    = pc_q;
  assign Mem_Rd      = (State == FETCH_INSTR) && !halted_q && !Reset;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[31:26];
  assign Rd          = instr_q[25:21];
  assign Rs1         = instr_q[20:16];
  assign Rs2         = instr_q[15:11];
  assign Imm_SExt    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign Cur_PC      = cur_pc_q;
  assign Link_PC     = cur_pc_q + ADDR_W'(1);
  assign Instr_Valid = valid_q;
  assign Halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: sequential fetch, decode,
// branch, halt, reset behaviour and PC wrap on a second instance.
module tb_instr_fetch_unit;

  localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_RO = 3'd2, S_EX = 3'd3, S_WB = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, branch_taken;
  logic [2:0]  state;
  logic [9:0]  branch_target;
  logic [9:0]  mem_addr, cur_pc, link_pc;
  logic        mem_rd, instr_valid, halted;
  logic [31:0] mem_data, instr, imm_sext;
  logic [5:0]  opcode;
  logic [4:0]  rd, rs1, rs2;

  logic        reset2;
  logic [2:0]  state2;
  logic [9:0]  mem_addr2, cur_pc2, link_pc2;
  logic        mem_rd2, instr_valid2, halted2;
  logic [31:0] instr2, imm_sext2;
  logic [5:0]  opcode2;
  logic [4:0]  rd2, rs12, rs22;

  logic [31:0] rom [0:1023];
  assign mem_data = rom[mem_addr];

  int testCount = 0;
  int failCount = 0;

  localparam logic [31:0] INSTR_A = 32'h12345678;
  localparam logic [31:0] INSTR_B = 32'h8C22FFFC;
  localparam logic [31:0] INSTR_C = 32'h20A50003;
  localparam logic [31:0] INSTR_H = 32'hFC000000;

  instr_fetch_unit dut (
    .Clk(clk), .Reset(reset), .State(state),
    .Mem_Addr(mem_addr), .Mem_Rd(mem_rd), .Mem_Data(mem_data),
    .Branch_Taken(branch_taken), .Branch_Target(branch_target),
    .Instr(instr), .Opcode(opcode), .Rd(rd), .Rs1(rs1), .Rs2(rs2),
    .Imm_SExt(imm_sext), .Cur_PC(cur_pc), .Link_PC(link_pc),
    .Instr_Valid(instr_valid), .Halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(10'h3FF), .HALT_OP(6'h3F)) dut_wrap (
    .Clk(clk), .Reset(reset2), .State(state2),
    .Mem_Addr(mem_addr2), .Mem_Rd(mem_rd2), .Mem_Data(32'hDEADBEEF),
    .Branch_Taken(1'b0), .Branch_Target(10'h000),
    .Instr(instr2), .Opcode(opcode2), .Rd(rd2), .Rs1(rs12), .Rs2(rs22),
    .Imm_SExt(imm_sext2), .Cur_PC(cur_pc2), .Link_PC(link_pc2),
    .Instr_Valid(instr_valid2), .Halted(halted2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the read strobe mid-cycle, then advance past the edge.
  task automatic applyStimulus(input logic [2:0] s, input logic bt, input logic [9:0] tgt,
                               input logic rst, input logic expRd);
    state = s; branch_taken = bt; branch_target = tgt; reset = rst;
    #1;
    checkOutput("mem_rd", {31'b0, mem_rd}, {31'b0, expRd});
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[0] = INSTR_A; rom[1] = INSTR_B; rom[2] = INSTR_C; rom[10'h40] = INSTR_H;
    reset = 1'b1; state = S_RST; branch_taken = 1'b0; branch_target = '0;
    reset2 = 1'b1; state2 = S_RST;

    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b1, 1'b0);
    checkOutput("rst_addr", {22'b0, mem_addr}, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_fields", {opcode, rd, rs1, rs2, 11'b0}, 32'h0);
    checkOutput("rst_imm", imm_sext, 32'h0);
    checkOutput("rst_curpc", {22'b0, cur_pc}, 32'h0);
    checkOutput("rst_linkpc", {22'b0, link_pc}, 32'h1);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("rst_halted", {31'b0, halted}, 32'h0);

    // Three sequential instructions; the third branches to 0x040.
    for (int i = 0; i < 3; i++) begin
      logic [31:0] expInstr;
      expInstr = (i == 0) ? INSTR_A : (i == 1) ? INSTR_B : INSTR_C;
      checkOutput("valid_pre_fetch", {31'b0, instr_valid}, 32'h0);
      applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b1);
      checkOutput("seq_instr", instr, expInstr);
      checkOutput("seq_curpc", {22'b0, cur_pc}, i);
      checkOutput("seq_addr", {22'b0, mem_addr}, i + 1);
      checkOutput("seq_linkpc", {22'b0, link_pc}, i + 1);
      checkOutput("seq_valid", {31'b0, instr_valid}, 32'h1);
      if (i == 1) begin
        checkOutput("dec_opcode", {26'b0, opcode}, 32'h23);
        checkOutput("dec_rd", {27'b0, rd}, 32'h1);
        checkOutput("dec_rs1", {27'b0, rs1}, 32'h2);
        checkOutput("dec_rs2", {27'b0, rs2}, 32'h1F);
        checkOutput("dec_imm", imm_sext, 32'hFFFFFFFC);
      end
      applyStimulus(S_RO, (i == 2), 10'h040, 1'b0, 1'b0);
      checkOutput("ro_addr", {22'b0, mem_addr}, i + 1);
      applyStimulus(S_EX, (i == 2), 10'h040, 1'b0, 1'b0);
      checkOutput("ex_addr", {22'b0, mem_addr}, (i == 2) ? 32'h40 : i + 1);
      applyStimulus(S_WB, 1'b0, 10'h0, 1'b0, 1'b0);
      checkOutput("wb_valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("wb_instr", instr, expInstr);
    end

    // Halt instruction at the branch target, with a competing branch request.
    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b1);
    checkOutput("br_curpc", {22'b0, cur_pc}, 32'h40);
    checkOutput("halt_instr", instr, INSTR_H);
    applyStimulus(S_RO, 1'b0, 10'h0, 1'b0, 1'b0);
    applyStimulus(S_EX, 1'b1, 10'h010, 1'b0, 1'b0);
    checkOutput("halt_set", {31'b0, halted}, 32'h1);
    checkOutput("halt_addr", {22'b0, mem_addr}, 32'h41);
    applyStimulus(S_WB, 1'b0, 10'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b0);
      checkOutput("halt_frozen_instr", instr, INSTR_H);
      checkOutput("halt_frozen_addr", {22'b0, mem_addr}, 32'h41);
      applyStimulus(S_RO, 1'b0, 10'h0, 1'b0, 1'b0);
      applyStimulus(S_EX, 1'b1, 10'h020, 1'b0, 1'b0);
      applyStimulus(S_WB, 1'b0, 10'h0, 1'b0, 1'b0);
      checkOutput("halt_sticky", {31'b0, halted}, 32'h1);
    end
    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b1, 1'b0);
    checkOutput("unhalt", {31'b0, halted}, 32'h0);
    checkOutput("unhalt_addr", {22'b0, mem_addr}, 32'h0);

    // Reset in EXECUTE beats a simultaneous branch.
    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b1);
    checkOutput("mid_fetch_addr", {22'b0, mem_addr}, 32'h1);
    applyStimulus(S_RO, 1'b0, 10'h0, 1'b0, 1'b0);
    applyStimulus(S_EX, 1'b1, 10'h055, 1'b1, 1'b0);
    checkOutput("mid_rst_addr", {22'b0, mem_addr}, 32'h0);
    checkOutput("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("mid_rst_instr", instr, 32'h0);

    // RESET_STATE clears like Reset; invalid states hold everything.
    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b1);
    applyStimulus(S_RST, 1'b0, 10'h0, 1'b0, 1'b0);
    checkOutput("rststate_addr", {22'b0, mem_addr}, 32'h0);
    checkOutput("rststate_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("rststate_instr", instr, 32'h0);
    applyStimulus(S_FETCH, 1'b0, 10'h0, 1'b0, 1'b1);
    applyStimulus(3'd5, 1'b1, 10'h077, 1'b0, 1'b0);
    applyStimulus(3'd7, 1'b0, 10'h0, 1'b0, 1'b0);
    checkOutput("inv_addr", {22'b0, mem_addr}, 32'h1);
    checkOutput("inv_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("inv_instr", instr, INSTR_A);

    // PC wrap on the instance reset to 0x3FF.
    @(posedge clk); #1;
    checkOutput("wrap_rst_addr", {22'b0, mem_addr2}, 32'h3FF);
    reset2 = 1'b0; state2 = S_FETCH;
    @(posedge clk); #1;
    checkOutput("wrap_curpc", {22'b0, cur_pc2}, 32'h3FF);
    checkOutput("wrap_addr", {22'b0, mem_addr2}, 32'h0);
    checkOutput("wrap_linkpc", {22'b0, link_pc2}, 32'h0);
    checkOutput("wrap_instr", instr2, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
